// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative multiply/divide unit producing HI/LO for MULT, MULTU,
// DIV and DIVU, with direct HI/LO writes for MTHI/MTLO.
// WIDTH must be even and >= 4; BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO are applied here
// RUN   | retiring BITS_PER_CYCLE bits per cycle, N = WIDTH/BITS_PER_CYCLE times
// FIX   | sign correction, hi/lo write-back, done pulse (also divide-by-zero exit)
module sm_muldiv #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;      // product high half, or partial remainder
  logic [WIDTH-1:0] qr;       // multiplier being shifted out, or quotient being shifted in
  logic [WIDTH-1:0] opB;      // multiplicand magnitude, or divisor magnitude
  logic             isDiv;
  logic             negLo;    // negate quotient (div) or whole product (mul)
  logic             negHi;    // negate remainder (div) or whole product (mul)
  logic             dbzPend;

  logic             isDivOp, signedOp, aNeg, bNeg, divZero;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH-1:0] accNext, qrNext;
  logic [WIDTH:0]   sum, remSh;
  logic [2*WIDTH-1:0] prod;

  // Operand decode at the accepting edge: magnitudes and result signs.
  always_comb begin
    isDivOp  = op[1] & ~op[2];
    signedOp = ~op[0];
    aNeg     = signedOp & srcA[WIDTH-1];
    bNeg     = signedOp & srcB[WIDTH-1];
    absA     = aNeg ? -srcA : srcA;
    absB     = bNeg ? -srcB : srcB;
    divZero  = isDivOp && (srcB == '0);
  end

  // One RUN iteration: BITS_PER_CYCLE radix-2 shift-add or restoring shift-subtract steps.
  always_comb begin
    accNext = acc;
    qrNext  = qr;
    sum     = '0;
    remSh   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (isDiv) begin
        remSh = {accNext, qrNext[WIDTH-1]};
        if (remSh >= {1'b0, opB}) begin
          // remainder stays below divisor, so the WIDTH-bit difference is exact
          accNext = remSh[WIDTH-1:0] - opB;
          qrNext  = {qrNext[WIDTH-2:0], 1'b1};
        end else begin
          accNext = remSh[WIDTH-1:0];
          qrNext  = {qrNext[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum     = {1'b0, accNext} + (qrNext[0] ? {1'b0, opB} : '0);
        qrNext  = {sum[0], qrNext[WIDTH-1:1]};
        accNext = sum[WIDTH:1];
      end
    end
  end

  // Signed product correction applied to the full double-width result.
  always_comb begin
    prod = negLo ? -{acc, qr} : {acc, qr};
  end

  // Busy covers RUN and FIX; done is visible only after FIX, back in IDLE.
  always_comb begin
    busy = (state != IDLE);
  end

  // Sequencer, datapath registers and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      qr          <= '0;
      opB         <= '0;
      isDiv       <= 1'b0;
      negLo       <= 1'b0;
      negHi       <= 1'b0;
      dbzPend     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              acc     <= '0;
              cnt     <= '0;
              isDiv   <= isDivOp;
              negLo   <= aNeg ^ bNeg;
              negHi   <= isDivOp ? aNeg : (aNeg ^ bNeg);
              qr      <= isDivOp ? absA : absB;
              opB     <= isDivOp ? absB : absA;
              dbzPend <= divZero;
              state   <= divZero ? FIX : RUN;
            end else if (op == 3'd4) begin
              hi <= srcA;
            end else if (op == 3'd5) begin
              lo <= srcA;
            end
          end
        end
        RUN: begin
          acc <= accNext;
          qr  <= qrNext;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state       <= IDLE;
          done        <= 1'b1;
          div_by_zero <= dbzPend;
          if (!dbzPend) begin
            if (isDiv) begin
              lo <= negLo ? -qr : qr;
              hi <= negHi ? -acc : acc;
            end else begin
              {hi, lo} <= prod;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_muldiv.sv
// Testbench for sm_muldiv: one instance with radix 2 and one with radix 16,
// table-driven mul/div vectors plus hand sequences for reset, MTHI/MTLO,
// divide-by-zero, ignored starts and illegal op codes.
module tb_sm_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [2:0]  op1, op4;
  logic [31:0] a1, b1, a4, b4;
  logic        busy1, done1, dbz1, busy4, done4, dbz4;
  logic [31:0] hi1, lo1, hi4, lo4;

  int total = 0;
  int bad   = 0;
  logic [31:0] mHi [2];
  logic [31:0] mLo [2];

  typedef struct {
    bit          u4;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eHi;
    logic [31:0] eLo;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  sm_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .srcA(a1), .srcB(b1),
    .busy(busy1), .done(done1), .div_by_zero(dbz1), .hi(hi1), .lo(lo1));

  sm_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .srcA(a4), .srcB(b4),
    .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4));

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit u4, input logic s, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    if (u4) begin
      start4 = s; op4 = o; a4 = a; b4 = b;
    end else begin
      start1 = s; op1 = o; a1 = a; b1 = b;
    end
  endtask

  function automatic logic gBusy(input bit u4); return u4 ? busy4 : busy1; endfunction
  function automatic logic gDone(input bit u4); return u4 ? done4 : done1; endfunction
  function automatic logic gDbz(input bit u4);  return u4 ? dbz4  : dbz1;  endfunction
  function automatic logic [31:0] gHi(input bit u4); return u4 ? hi4 : hi1; endfunction
  function automatic logic [31:0] gLo(input bit u4); return u4 ? lo4 : lo1; endfunction

  // Issue one mul/div and follow it to done; returns in the done cycle so the
  // next call starts back-to-back on that same cycle.
  task automatic runOp(input bit u4, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                       input logic eDbz, input int eLat, input string name);
    int lat;
    bit busyBad, holdBad;
    drive(u4, 1'b1, o, a, b);
    step();
    drive(u4, 1'b0, 3'd0, $urandom, $urandom);
    lat = 0;
    busyBad = 0;
    holdBad = 0;
    while (!gDone(u4) && lat < 200) begin
      if (gBusy(u4) !== 1'b1) busyBad = 1;
      if (gHi(u4) !== mHi[u4] || gLo(u4) !== mLo[u4]) holdBad = 1;
      step();
      lat++;
    end
    check32({name, ".latency"}, 32'(lat), 32'(eLat));
    checkBit({name, ".busyRun"}, busyBad, 1'b0);
    checkBit({name, ".hold"}, holdBad, 1'b0);
    checkBit({name, ".busyDone"}, gBusy(u4), 1'b0);
    checkBit({name, ".dbz"}, gDbz(u4), eDbz);
    check32({name, ".hi"}, gHi(u4), eHi);
    check32({name, ".lo"}, gLo(u4), eLo);
    mHi[u4] = eHi;
    mLo[u4] = eLo;
  endtask

  initial begin
    int lat;
    bit seenDone;

    rst = 1'b1;
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 3'd0, 32'h0, 32'h0);
    mHi[0] = '0; mLo[0] = '0; mHi[1] = '0; mLo[1] = '0;
    step();
    step();
    rst = 1'b0;
    check32("reset.hi1", hi1, 32'h0);
    check32("reset.lo1", lo1, 32'h0);
    checkBit("reset.busy1", busy1, 1'b0);
    checkBit("reset.done1", done1, 1'b0);
    checkBit("reset.dbz1", dbz1, 1'b0);
    check32("reset.hi4", hi4, 32'h0);
    check32("reset.lo4", lo4, 32'h0);
    checkBit("reset.busy4", busy4, 1'b0);
    checkBit("reset.done4", done4, 1'b0);
    checkBit("reset.dbz4", dbz4, 1'b0);

    vecs.push_back('{0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, "multu_max"});
    vecs.push_back('{0, 3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, "mult_m3x5"});
    vecs.push_back('{0, 3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       33, "divu_100_7"});
    vecs.push_back('{0, 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_m7_2"});
    vecs.push_back('{0, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, "div_min_m1"});
    vecs.push_back('{0, 3'd0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 33, "mult_7xm2"});
    vecs.push_back('{0, 3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, "div_7_m2"});
    vecs.push_back('{0, 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, "mult_minxmin"});
    vecs.push_back('{0, 3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33, "divu_max_1"});
    vecs.push_back('{1, 3'd1, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF, 9,  "r4_multu"});
    vecs.push_back('{1, 3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 9,  "r4_divu"});
    vecs.push_back('{1, 3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 9,  "r4_mult"});
    vecs.push_back('{1, 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 9,  "r4_div"});

    foreach (vecs[i])
      runOp(vecs[i].u4, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eHi, vecs[i].eLo,
            1'b0, vecs[i].lat, vecs[i].name);
    step();

    // illegal op codes leave everything untouched
    drive(0, 1'b1, 3'd6, 32'h11111111, 32'h22222222);
    step();
    checkBit("op6.busy", busy1, 1'b0);
    drive(0, 1'b1, 3'd7, 32'h33333333, 32'h44444444);
    step();
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
    checkBit("op7.busy", busy1, 1'b0);
    checkBit("op7.done", done1, 1'b0);
    check32("op7.hi", hi1, mHi[0]);
    check32("op7.lo", lo1, mLo[0]);

    // MTHI / MTLO preload, then divide by zero
    drive(0, 1'b1, 3'd4, 32'h00001234, 32'h0);
    step();
    check32("mthi.hi", hi1, 32'h00001234);
    checkBit("mthi.busy", busy1, 1'b0);
    mHi[0] = 32'h00001234;
    drive(0, 1'b1, 3'd5, 32'h00005678, 32'h0);
    step();
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
    check32("mtlo.lo", lo1, 32'h00005678);
    checkBit("mtlo.done", done1, 1'b0);
    mLo[0] = 32'h00005678;
    runOp(0, 3'd3, 32'd9, 32'd0, 32'h00001234, 32'h00005678, 1'b1, 1, "divu_by0");
    step();
    checkBit("divu_by0.donePulse", done1, 1'b0);
    checkBit("divu_by0.dbzPulse", dbz1, 1'b0);

    // starts during RUN are ignored, MTLO included
    drive(0, 1'b1, 3'd1, 32'd3, 32'd4);
    step();
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
    lat = 0;
    repeat (3) begin step(); lat++; end
    drive(0, 1'b1, 3'd5, 32'h0000AAAA, 32'h0);
    step(); lat++;
    check32("ign.mtlo", lo1, 32'h00005678);
    drive(0, 1'b1, 3'd2, 32'd8, 32'd2);
    step(); lat++;
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
    while (!done1 && lat < 200) begin step(); lat++; end
    check32("ign.latency", 32'(lat), 32'd33);
    check32("ign.hi", hi1, 32'h0);
    check32("ign.lo", lo1, 32'd12);
    step();
    checkBit("ign.notQueued", busy1, 1'b0);
    mHi[0] = 32'h0; mLo[0] = 32'd12;

    // reset in the middle of RUN aborts without a done pulse
    drive(0, 1'b1, 3'd1, 32'h0000FFFF, 32'h0000FFFF);
    step();
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (9) step();
    checkBit("abort.busyBefore", busy1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check32("abort.hi", hi1, 32'h0);
    check32("abort.lo", lo1, 32'h0);
    checkBit("abort.busy", busy1, 1'b0);
    seenDone = 0;
    repeat (40) begin
      if (done1) seenDone = 1;
      step();
    end
    checkBit("abort.noDone", seenDone, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_muldiv.md
Name: sm_muldiv

Overview:
- Iterative multiply/divide unit for the schoolMIPS core, producing the HI/LO pair for MULT, MULTU, DIV and DIVU, and accepting direct writes for MTHI and MTLO.
- Runs alongside the single-cycle ALU; the control unit stalls the PC while busy is high and reads hi/lo for MFHI/MFLO.
- Parametrised in operand width and in radix (bits retired per cycle), which the single-cycle ALU cannot provide.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 4.
- BITS_PER_CYCLE, 1, bits retired per iteration; legal values are 1, 2 and 4, and the value must divide WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- start  input  1  request; sampled on the rising edge.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are illegal.
- srcA  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- srcB  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in progress; new starts are ignored.
- done  output  1  one-cycle pulse when hi/lo are updated by a mul/div.
- div_by_zero  output  1  one-cycle pulse coincident with done on a zero divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Reset mid-operation aborts the operation; no done pulse is produced.
- Let N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, RUN, FIX.
- IDLE, accepting edge (start=1, op in 0..3, divisor nonzero for div):
  - latch operand magnitudes (absolute values for signed ops), result signs and op;
  - clear the iteration counter;
  - go to RUN; busy=1 from the next cycle.
- RUN: each edge retires BITS_PER_CYCLE bits.
  - Multiply: shift-add on the {acc, multiplier} register.
  - Divide: restoring shift-subtract on the {rem, quotient} register.
  - After the N-th iteration edge, go to FIX.
- FIX, one edge:
  - apply sign correction;
  - write hi/lo;
  - done=1 for exactly the following cycle; busy=0;
  - go to IDLE.
- Latency: done is high N+1 cycles after the accepting edge; busy is high for those N+1 cycles. For WIDTH=32, BITS_PER_CYCLE=1 this is 33; for BITS_PER_CYCLE=4 it is 9.
- A new start is accepted on the same edge that done is visible, since the state is IDLE by then.
- hi/lo hold their previous values throughout RUN; partial results are never visible.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned respectively.
- DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
- DIV with MIN / -1: lo=MIN, hi=0, no flag.
- DIVU: unsigned quotient in lo, remainder in hi.
- Divide by zero (op 2/3, srcB=0 at the accepting edge):
  - go directly to FIX with no iterations;
  - hi/lo are unchanged;
  - done=1 and div_by_zero=1 for one cycle, one cycle after accept;
  - busy is high for that one cycle only.
- MTHI/MTLO in IDLE: hi (or lo) = srcA at the accepting edge; busy, done and div_by_zero stay 0.
- start=1 while busy=1: ignored entirely, including MTHI/MTLO; nothing is queued.
- Illegal op codes 6/7: ignored; no state change.
- Operands are sampled only at the accepting edge; later changes to srcA/srcB/op have no effect.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF (WIDTH=32, BITS_PER_CYCLE=1) -> busy high 33 cycles; done pulse at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; hi/lo hold the old values until then.
- MULT 0xFFFFFFFD (-3) * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Follow with back-to-back DIVU 100/7 started on the done cycle -> lo=14, hi=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Preload MTHI 0x1234 and MTLO 0x5678; then DIVU 9/0 -> done and div_by_zero high one cycle after accept; busy high 1 cycle; hi=0x1234, lo=0x5678.
- Start MULTU 3*4; during RUN assert start with MTLO 0xAAAA and with DIV 8/2 -> both ignored; result hi=0, lo=12. Start MULTU again and assert rst at cycle 10 -> hi=lo=0, busy=0, no done pulse.
- BITS_PER_CYCLE=4: MULTU 0x0000FFFF*0x00010001 -> done at cycle 9; hi=0x00000000, lo=0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
